// File: rtl/mips_instr_memory_ws_if.sv
// Fetch bus between the MIPS instruction port and the wait-state instruction memory.
interface mips_instr_memory_ws_if;
   logic        instr_read;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;
   logic        instr_valid;
   logic        instr_busy;
   logic        addr_fault;
   logic [31:0] fetch_count;

   modport master (
      output instr_read, instr_address,
      input  instr_readdata, instr_valid, instr_busy, addr_fault, fetch_count
   );

   modport slave (
      input  instr_read, instr_address,
      output instr_readdata, instr_valid, instr_busy, addr_fault, fetch_count
   );
endinterface

// File: rtl/mips_instr_memory_ws.sv
// Instruction memory with request/valid handshake, wait states, fault/halt mapping and fetch counter.
// Optional backdoor write port enabled by defining MIPS_IMEM_PROG_EN.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | request latched, wait counter running down to its terminal count
// RESP  | instr_valid showing for one cycle; a held request is accepted here
module mips_instr_memory_ws #(
   parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
   parameter int          DEPTH_WORDS = 64,
   parameter int          WAIT_CYCLES = 0,
   parameter string       INIT_FILE   = "",
   parameter bit          BYTE_SWAP   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
`ifdef MIPS_IMEM_PROG_EN
   input  logic        prog_we,
   input  logic [15:0] prog_index,
   input  logic [31:0] prog_data,
`endif
   mips_instr_memory_ws_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [31:0] mem [DEPTH_WORDS];

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [29:0] word_off;
   logic        halt;
   logic        misaligned;
   logic        out_range;
   logic        fault_c;
   logic [31:0] rd_word;
   logic [31:0] fetch_word;
   logic        accept;

   // Every word starts as NOP at time zero.
   initial begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
   end

   // Unsigned subtraction: addresses below the base wrap to a huge index and fault.
   assign word_off   = 30'((addr_q - BASE_ADDR) >> 2);
   assign halt       = (addr_q == 32'h0);
   assign misaligned = (addr_q[1:0] != 2'b00);
   assign out_range  = ({2'b00, word_off} >= 32'(DEPTH_WORDS));
   assign fault_c    = !halt && (misaligned || out_range);
   assign rd_word    = mem[word_off[AW-1:0]];

   always_comb begin
      fetch_word = '0;
      if (!halt && !fault_c) begin
         if (BYTE_SWAP) fetch_word = {rd_word[7:0], rd_word[15:8], rd_word[23:16], rd_word[31:24]};
         else           fetch_word = rd_word;
      end
   end

   assign accept = bus.instr_read && ((state == IDLE) || (state == RESP));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state              <= IDLE;
         cnt                <= '0;
         addr_q             <= '0;
         bus.instr_readdata <= '0;
         bus.instr_valid    <= 1'b0;
         bus.instr_busy     <= 1'b0;
         bus.addr_fault     <= 1'b0;
         bus.fetch_count    <= '0;
      end else if (clk_enable) begin
         bus.instr_valid <= 1'b0;
         bus.addr_fault  <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  addr_q         <= bus.instr_address;
                  cnt            <= 4'(WAIT_CYCLES);
                  bus.instr_busy <= 1'b1;
                  state          <= WAIT;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state              <= RESP;
                  bus.instr_busy     <= 1'b0;
                  bus.instr_valid    <= 1'b1;
                  bus.addr_fault     <= fault_c;
                  bus.instr_readdata <= fetch_word;
                  bus.fetch_count    <= bus.fetch_count + 32'd1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state          <= IDLE;
               bus.instr_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef MIPS_IMEM_PROG_EN
   // Nonblocking write: a fetch reading the same word on this edge still sees the old value.
   always_ff @(posedge clk) begin
      if (clk_enable && prog_we && ({16'h0, prog_index} < 32'(DEPTH_WORDS)))
         mem[prog_index[AW-1:0]] <= prog_data;
   end
`endif

endmodule

// File: tb/tb_mips_instr_memory_ws.sv
// Directed bench for mips_instr_memory_ws: three instances with 0, 3 and 5 wait states.
module tb_mips_instr_memory_ws;

   logic clk;
   logic reset;
   logic clk_enable;
   int   vectors;
   int   miscompares;

`ifdef MIPS_IMEM_PROG_EN
   logic        prog_we;
   logic [15:0] prog_index;
   logic [31:0] prog_data;
`endif

   mips_instr_memory_ws_if b0 ();
   mips_instr_memory_ws_if b3 ();
   mips_instr_memory_ws_if b5 ();

`ifdef MIPS_IMEM_PROG_EN
   mips_instr_memory_ws #(.WAIT_CYCLES(0)) u0 (.clk(clk), .reset(reset), .clk_enable(clk_enable),
      .prog_we(prog_we), .prog_index(prog_index), .prog_data(prog_data), .bus(b0));
   mips_instr_memory_ws #(.WAIT_CYCLES(3)) u3 (.clk(clk), .reset(reset), .clk_enable(clk_enable),
      .prog_we(prog_we), .prog_index(prog_index), .prog_data(prog_data), .bus(b3));
   mips_instr_memory_ws #(.WAIT_CYCLES(5)) u5 (.clk(clk), .reset(reset), .clk_enable(clk_enable),
      .prog_we(prog_we), .prog_index(prog_index), .prog_data(prog_data), .bus(b5));
`else
   mips_instr_memory_ws #(.WAIT_CYCLES(0)) u0 (.clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(b0));
   mips_instr_memory_ws #(.WAIT_CYCLES(3)) u3 (.clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(b3));
   mips_instr_memory_ws #(.WAIT_CYCLES(5)) u5 (.clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(b5));
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word_of(input int i);
      case (i)
         0:       return 32'h24010020;
         1:       return 32'h8C220004;
         2:       return 32'h04610003;
         63:      return 32'hDEADBEEF;
         default: return {8'(i), 8'hC3, 8'h5A, 8'(8'hF0 ^ 8'(i))};
      endcase
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Single fetch on the zero-wait instance: accept edge, then response edge.
   task automatic fetch0(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input logic exp_f);
      b0.instr_read    = 1'b1;
      b0.instr_address = a;
      tick();
      chk({tag, ".busy"}, 32'(b0.instr_busy), 32'd1);
      tick();
      chk({tag, ".valid"}, 32'(b0.instr_valid), 32'd1);
      chk({tag, ".data"}, b0.instr_readdata, exp_d);
      chk({tag, ".fault"}, 32'(b0.addr_fault), 32'(exp_f));
      b0.instr_read = 1'b0;
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      clk_enable  = 1'b1;
      b0.instr_read = 1'b0; b0.instr_address = '0;
      b3.instr_read = 1'b0; b3.instr_address = '0;
      b5.instr_read = 1'b0; b5.instr_address = '0;
`ifdef MIPS_IMEM_PROG_EN
      prog_we = 1'b0; prog_index = '0; prog_data = '0;
      #1;
      // Image written through the backdoor while reset is still held low.
      for (int i = 0; i < 64; i++) begin
         prog_we = 1'b1; prog_index = 16'(i); prog_data = word_of(i);
         tick();
      end
      prog_we = 1'b0;
`else
      #1;
      for (int i = 0; i < 64; i++) begin
         u0.mem[i] = word_of(i);
         u3.mem[i] = word_of(i);
         u5.mem[i] = word_of(i);
      end
`endif
      tick();
      tick();
      chk("rst.data",  b0.instr_readdata, 32'h0);
      chk("rst.valid", 32'(b0.instr_valid), 32'd0);
      chk("rst.busy",  32'(b0.instr_busy), 32'd0);
      chk("rst.fault", 32'(b0.addr_fault), 32'd0);
      chk("rst.count", b0.fetch_count, 32'd0);
      reset = 1'b1;
      tick();

      fetch0("basic", 32'hBFC00000, 32'h20000124, 1'b0);
      chk("basic.count", b0.fetch_count, 32'd1);
      chk("basic.drop", 32'(b0.instr_valid), 32'd0);

      // Wait states with the address moved after acceptance.
      b3.instr_read = 1'b1; b3.instr_address = 32'hBFC00008;
      tick();
      b3.instr_address = 32'hBFC00000;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ws.busy%0d", k), 32'(b3.instr_busy), 32'd1);
         chk($sformatf("ws.nv%0d", k), 32'(b3.instr_valid), 32'd0);
         tick();
      end
      chk("ws.valid", 32'(b3.instr_valid), 32'd1);
      chk("ws.data",  b3.instr_readdata, 32'h03006104);
      chk("ws.busy_end", 32'(b3.instr_busy), 32'd0);
      b3.instr_read = 1'b0;
      tick();

      fetch0("misalign", 32'hBFC00006, 32'h0, 1'b1);
      fetch0("oor",      32'hBFC00100, 32'h0, 1'b1);
      fetch0("halt",     32'h00000000, 32'h0, 1'b0);
      fetch0("last",     32'hBFC000FC, 32'hEFBEADDE, 1'b0);
      fetch0("below",    32'hBFBFFFFC, 32'h0, 1'b1);
      chk("fault.count", b0.fetch_count, 32'd6);

      // Reset two cycles into a five-wait fetch.
      b5.instr_read = 1'b1; b5.instr_address = 32'hBFC00000;
      tick();
      tick();
      reset = 1'b0; b5.instr_read = 1'b0;
      tick();
      chk("abort.busy",  32'(b5.instr_busy), 32'd0);
      chk("abort.valid", 32'(b5.instr_valid), 32'd0);
      chk("abort.data",  b5.instr_readdata, 32'h0);
      chk("abort.count0", b0.fetch_count, 32'd0);
      reset = 1'b1;
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("abort.nv%0d", k), 32'(b5.instr_valid), 32'd0);
         tick();
      end

      b5.instr_read = 1'b1; b5.instr_address = 32'hBFC00008;
      tick();
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("post.busy%0d", k), 32'(b5.instr_busy), 32'd1);
         tick();
      end
      chk("post.valid", 32'(b5.instr_valid), 32'd1);
      chk("post.data",  b5.instr_readdata, 32'h03006104);
      chk("post.count", b5.fetch_count, 32'd1);
      b5.instr_read = 1'b0;
      tick();

      // Freeze three cycles inside WAIT.
      b5.instr_read = 1'b1; b5.instr_address = 32'hBFC00000;
      tick();
      tick();
      tick();
      clk_enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("frz.busy%0d", k), 32'(b5.instr_busy), 32'd1);
         chk($sformatf("frz.nv%0d", k), 32'(b5.instr_valid), 32'd0);
      end
      clk_enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("frz.late%0d", k), 32'(b5.instr_valid), 32'd0);
      end
      tick();
      chk("frz.valid", 32'(b5.instr_valid), 32'd1);
      chk("frz.data",  b5.instr_readdata, 32'h20000124);
      chk("frz.count", b5.fetch_count, 32'd2);
      b5.instr_read = 1'b0;
      clk_enable = 1'b0;
      tick();
      chk("hold.valid", 32'(b5.instr_valid), 32'd1);
      chk("hold.count", b5.fetch_count, 32'd2);
      clk_enable = 1'b1;
      tick();
      chk("hold.release", 32'(b5.instr_valid), 32'd0);

      // Streaming with the request held high.
      b0.instr_read = 1'b1; b0.instr_address = 32'hBFC00000;
      for (int i = 0; i < 13; i++) begin
         tick();
         chk($sformatf("strm.nv%0d", i), 32'(b0.instr_valid), 32'd0);
         tick();
         chk($sformatf("strm.v%0d", i), 32'(b0.instr_valid), 32'd1);
         chk($sformatf("strm.d%0d", i), b0.instr_readdata, bswap(word_of(i)));
         b0.instr_address = 32'hBFC00000 + 32'(4 * (i + 1));
      end
      b0.instr_read = 1'b0;
      tick();
      chk("strm.count", b0.fetch_count, 32'd13);
      chk("strm.idle", 32'(b0.instr_busy), 32'd0);

`ifdef MIPS_IMEM_PROG_EN
      prog_we = 1'b1; prog_index = 16'd1; prog_data = 32'h00011823;
      tick();
      prog_we = 1'b0;
      fetch0("bd.write", 32'hBFC00004, 32'h23180100, 1'b0);
      b0.instr_read = 1'b1; b0.instr_address = 32'hBFC00004;
      tick();
      prog_we = 1'b1; prog_index = 16'd1; prog_data = 32'hCAFEF00D;
      tick();
      prog_we = 1'b0;
      chk("bd.same_edge", b0.instr_readdata, 32'h23180100);
      b0.instr_read = 1'b0;
      tick();
      fetch0("bd.new", 32'hBFC00004, 32'h0DF0FECA, 1'b0);
      clk_enable = 1'b0;
      prog_we = 1'b1; prog_index = 16'd1; prog_data = 32'h11111111;
      tick();
      prog_we = 1'b0;
      clk_enable = 1'b1;
      fetch0("bd.frozen", 32'hBFC00004, 32'h0DF0FECA, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
